cabac_ctx_mgr: RTL
==================

CABAC_CTX_MGR -- requirements
Module: cabac_ctx_mgr

Interface
REQ-001 SHALL have parameter CTX_NUM, default 192, number of context entries.
REQ-002 SHALL have parameter CTX_IDX_W, default 8, context index width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_init_i  input  1  one-cycle pulse requesting a context-table initialisation.
REQ-006 SHALL have port init_ctx_i  input  7  init value {mps, pStateIdx[5:0]}, sampled with start_init_i.
REQ-007 SHALL have port init_done_o  output  1  one-cycle pulse when initialisation completes.
REQ-008 SHALL have port bin_valid_i  input  1  bin request valid.
REQ-009 SHALL have port bin_ready_o  output  1  request accepted on an edge where bin_valid_i & bin_ready_o.
REQ-010 SHALL have port bin_ctx_idx_i  input  CTX_IDX_W  context index of the request.
REQ-011 SHALL have port bin_val_i  input  1  bin value to be coded.
REQ-012 SHALL have port out_valid_o  output  1  result valid; no backpressure.
REQ-013 SHALL have port out_ctx_o  output  7  pre-update context for the accepted bin.
REQ-014 SHALL have port out_bin_o  output  1  bin value matching out_ctx_o.
REQ-015 SHALL have port err_o  output  1  one-cycle pulse on an out-of-range index.

Function
REQ-016 SHALL hold CTX_NUM x 7-bit context storage with a registered (synchronous) read.
REQ-017 SHALL run FSM IDLE -> INIT on start_init_i, INIT -> RUN after the last init write, and RUN -> INIT on start_init_i.
REQ-018 SHALL ignore start_init_i while in INIT.
REQ-019 SHALL write the latched init value to index 0..CTX_NUM-1 in INIT, one index per cycle, over exactly CTX_NUM cycles.
REQ-020 SHALL pulse init_done_o in the cycle the FSM enters RUN.
REQ-021 SHALL drive bin_ready_o high only in RUN, and low in the cycle start_init_i is sampled.
REQ-022 SHALL, on acceptance at edge k, register the index, the bin and the read context, then assert out_valid_o for the cycle after edge k (latency 1).
REQ-023 SHALL sustain one request per cycle.
REQ-024 SHALL compute the updated context with the HEVC transition: MPS increments the state, saturating at 62; LPS follows the LPS table; LPS at state 0 flips the mps bit.
REQ-025 SHALL write the updated context back at edge k+1.
REQ-026 SHALL, on back-to-back requests to the same index, register the updated value (not the stale storage read) as the next request's context.
REQ-027 SHALL, for an index >= CTX_NUM, accept the request, output out_ctx_o = 7'h00 with out_valid_o, pulse err_o, and skip the write.
REQ-028 SHALL, when start_init_i arrives while a write-back is pending, complete that write at the same edge, so the init sweep overwrites it.
REQ-029 SHALL drive out_ctx_o and out_bin_o to 0 when out_valid_o is low.

Reset
REQ-030 SHALL on rst force FSM = IDLE, init counter = 0, and all outputs to 0 asynchronously.
REQ-031 SHALL NOT reset the context storage; its contents are undefined until an init completes.
REQ-032 SHALL abandon a sweep when rst is asserted mid-INIT; the block stays in IDLE until the next start_init_i.

Structure
REQ-033 SHALL place CTX_NUM, CTX_IDX_W, the context width (7) and the FSM state encodings in package cabac_ctx_pkg.
REQ-034 SHALL instantiate the existing combinational transition block cabac_ucontext_t once for the update; no other sub-modules.

Verification
REQ-035 SHALL cover: init 7'h1A; bin 0 at idx 3, then idx 3 again two cycles later -> out_ctx_o 7'h1A, then 7'h1B.
REQ-036 SHALL cover: init 7'h05; three consecutive bin-0 requests to idx 7 -> out_ctx_o 7'h05, 7'h06, 7'h07 on consecutive cycles.
REQ-037 SHALL cover: init 7'h00; bin 1 at idx 0 twice back-to-back -> out_ctx_o 7'h00, then 7'h40.
REQ-038 SHALL cover: init 7'h3E; bin 0 at idx 10 twice -> out_ctx_o 7'h3E, then 7'h3E (saturation).
REQ-039 SHALL cover: idx 200 -> out_ctx_o 7'h00 and err_o pulse; a later request to idx 8 returns the init value, proving no write occurred.
REQ-040 SHALL cover: rst at init cycle 50 -> IDLE, bin_ready_o 0; re-init -> init_done_o exactly 192 cycles after start_init_i.

Source files
------------

// File: rtl/cabac_ctx_pkg.sv
// Shared constants, FSM encoding and HEVC LPS state-transition table for the CABAC context manager.
// Constants only; no timing or flow-control behaviour lives here.
package cabac_ctx_pkg;

  localparam int CTX_NUM   = 192;
  localparam int CTX_IDX_W = 8;
  localparam int CTX_W     = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } ctx_state_t;

  // Next pStateIdx after an LPS, indexed by the current pStateIdx.
  localparam logic [0:63][5:0] LPS_NEXT = {
    6'd0,  6'd0,  6'd1,  6'd2,  6'd2,  6'd4,  6'd4,  6'd5,
    6'd6,  6'd7,  6'd8,  6'd9,  6'd9,  6'd11, 6'd11, 6'd12,
    6'd13, 6'd13, 6'd15, 6'd15, 6'd16, 6'd16, 6'd18, 6'd18,
    6'd19, 6'd19, 6'd21, 6'd21, 6'd22, 6'd22, 6'd23, 6'd24,
    6'd24, 6'd25, 6'd26, 6'd26, 6'd27, 6'd27, 6'd28, 6'd29,
    6'd29, 6'd30, 6'd30, 6'd30, 6'd31, 6'd32, 6'd32, 6'd33,
    6'd33, 6'd33, 6'd34, 6'd34, 6'd35, 6'd35, 6'd35, 6'd36,
    6'd36, 6'd36, 6'd37, 6'd37, 6'd37, 6'd38, 6'd38, 6'd63
  };

endpackage

// File: rtl/cabac_ucontext_t.sv
// Combinational HEVC context update: {mps, pStateIdx} x bin -> next context.
// Zero latency; no flow control.
module cabac_ucontext_t
  import cabac_ctx_pkg::*;
(
  input  logic [CTX_W-1:0] ctx_cur,
  input  logic             bin_val,
  output logic [CTX_W-1:0] ctx_nxt
);

  logic       mps;
  logic [5:0] st;

  assign mps = ctx_cur[6];
  assign st  = ctx_cur[5:0];

  always_comb begin
    ctx_nxt = ctx_cur;
    if (bin_val == mps) begin
      if (st < 6'd62) ctx_nxt[5:0] = st + 6'd1;
    end else begin
      ctx_nxt[5:0] = LPS_NEXT[st];
      if (st == 6'd0) ctx_nxt[6] = ~mps;
    end
  end

endmodule

// File: rtl/cabac_ctx_mgr.sv
// CABAC context table: init sweep of CTX_NUM cycles, then one bin per cycle with 1-cycle result latency.
// bin_ready_o is high only in RUN (dropped while start_init_i is sampled); results have no backpressure.
module cabac_ctx_mgr #(
  parameter int CTX_NUM   = cabac_ctx_pkg::CTX_NUM,
  parameter int CTX_IDX_W = cabac_ctx_pkg::CTX_IDX_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_init_i,
  input  logic [cabac_ctx_pkg::CTX_W-1:0] init_ctx_i,
  output logic                            init_done_o,
  input  logic                            bin_valid_i,
  output logic                            bin_ready_o,
  input  logic [CTX_IDX_W-1:0]            bin_ctx_idx_i,
  input  logic                            bin_val_i,
  output logic                            out_valid_o,
  output logic [cabac_ctx_pkg::CTX_W-1:0] out_ctx_o,
  output logic                            out_bin_o,
  output logic                            err_o
);

  import cabac_ctx_pkg::*;

  ctx_state_t             state_q, state_nxt;
  logic [CTX_IDX_W-1:0]   cnt_q;
  logic [CTX_W-1:0]       init_q;
  logic                   done_q;
  logic                   init_we, init_last;

  logic                   v_q, err_q, bin_q;
  logic [CTX_IDX_W-1:0]   idx_q;
  logic [CTX_W-1:0]       ctx_q, upd;
  logic                   accept, in_range, wb_en, fwd;

  logic [CTX_W-1:0]       mem [CTX_NUM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (start_init_i) state_nxt = ST_INIT;
      ST_INIT: if (init_last)    state_nxt = ST_RUN;
      ST_RUN:  if (start_init_i) state_nxt = ST_INIT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bin_ready_o = (state_q == ST_RUN) && !start_init_i;
    init_we     = (state_q == ST_INIT);
    init_last   = init_we && (cnt_q == CTX_IDX_W'(CTX_NUM - 1));
    init_done_o = done_q;
  end

  assign accept   = bin_valid_i && bin_ready_o;
  assign in_range = int'(bin_ctx_idx_i) < CTX_NUM;
  assign wb_en    = v_q && !err_q;
  // A request to the index being written back this edge must see the new value, not the stale read.
  assign fwd      = wb_en && (idx_q == bin_ctx_idx_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      init_q <= '0;
      done_q <= 1'b0;
      v_q    <= 1'b0;
      err_q  <= 1'b0;
      bin_q  <= 1'b0;
      idx_q  <= '0;
      ctx_q  <= '0;
    end else begin
      done_q <= init_last;
      cnt_q  <= init_we ? cnt_q + CTX_IDX_W'(1) : '0;
      if (start_init_i && state_q != ST_INIT) init_q <= init_ctx_i;
      v_q    <= accept;
      err_q  <= accept && !in_range;
      if (accept) begin
        idx_q <= bin_ctx_idx_i;
        bin_q <= bin_val_i;
        ctx_q <= !in_range ? '0 : (fwd ? upd : mem[bin_ctx_idx_i]);
      end
    end
  end

  // Storage is deliberately not reset; a pending write-back lands on the same edge an init starts.
  always_ff @(posedge clk) begin
    if (init_we)    mem[cnt_q] <= init_q;
    else if (wb_en) mem[idx_q] <= upd;
  end

  cabac_ucontext_t u_upd (
    .ctx_cur (ctx_q),
    .bin_val (bin_q),
    .ctx_nxt (upd)
  );

  assign out_valid_o = v_q;
  assign out_ctx_o   = v_q ? ctx_q : '0;
  assign out_bin_o   = v_q && bin_q;
  assign err_o       = v_q && err_q;

endmodule
